// File: rtl/alu_result_router.sv
// rtl/alu_result_router.sv - routes one result stream to eight one-entry valid/ready channels
// Optional per-channel drain counters are enabled with `define ROUTE_CNT_EN.
module alu_result_router #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [2:0]           in_sel,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 any_pending,
  input  logic [2:0]           cnt_sel,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_out
);

  logic [NCH-1:0]       valid_q;
  logic [NCH*WIDTH-1:0] data_q;
  logic [NCH-1:0]       load;
  logic [NCH-1:0]       drain;

  // A channel can take a new word if empty or being drained on this same edge.
  assign in_ready = !valid_q[in_sel] || out_ready[in_sel];

  always_comb begin
    load = '0;
    if (in_valid && in_ready) load[in_sel] = 1'b1;
  end

  assign drain = valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          valid_q[i]                <= 1'b1;
          data_q[i*WIDTH +: WIDTH]  <= in_data;
        end else if (drain[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign any_pending = |valid_q;

`ifdef ROUTE_CNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];

  // Clear wins over increment; counters stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (drain[i] && (cnt_q[i] != {CNT_W{1'b1}})) cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  assign cnt_out = cnt_q[cnt_sel];
`else
  logic unused_cnt;
  assign unused_cnt = ^{cnt_sel, cnt_clr};
  assign cnt_out    = '0;
`endif

endmodule

// File: tb/tb_alu_result_router.sv
// tb/tb_alu_result_router.sv - scoreboard bench for alu_result_router
// Build with ROUTE_CNT_EN defined to exercise the counters at CNT_W = 4.
module tb_alu_result_router;

`ifdef ROUTE_CNT_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_data = '0;
  logic [2:0]    in_sel = '0;
  logic [7:0]    out_valid;
  logic [7:0]    out_ready = '0;
  logic [255:0]  out_data;
  logic          any_pending;
  logic [2:0]    cnt_sel = '0;
  logic          cnt_clr = 1'b0;
  logic [CNT_W-1:0] cnt_out;

  alu_result_router #(.WIDTH(32), .NCH(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .any_pending(any_pending),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  ch;
    logic [31:0] d;
  } ent_t;

  ent_t sbq[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Drive a word; expected readiness is decided by the caller from the test scenario.
  task automatic send(input logic [2:0] sel, input logic [31:0] d, input logic exp_rdy);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    #1;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (exp_rdy) sbq.push_back({sel, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every handshake that completes on the next edge must match a pushed word.
  always @(negedge clk) begin
    int idx;
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          idx = -1;
          for (int k = 0; k < sbq.size(); k++)
            if (idx < 0 && sbq[k].ch == 3'(i)) idx = k;
          if (idx < 0) begin
            n_total++;
            $display("FAIL unexpected_word: channel %0d got %0h expected none", i, out_data[i*32 +: 32]);
          end else begin
            check($sformatf("drain_ch%0d", i), out_data[i*32 +: 32], sbq[idx].d);
            sbq.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    // Reset asserted mid-cycle before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {24'd0, out_valid}, 32'h0);
    check("rst_any_pending", {31'd0, any_pending}, 32'h0);
    check("rst_in_ready", {31'd0, in_ready}, 32'h1);
    check("rst_out_data_or", {31'd0, |out_data}, 32'h0);
    check("rst_cnt_out", 32'(cnt_out), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single route to channel 3
    send(3'd3, 32'hDEADBEEF, 1'b1);
    tick();
    in_valid = 1'b0;
    check("single_valid", {24'd0, out_valid}, 32'h08);
    check("single_slice3", out_data[3*32 +: 32], 32'hDEADBEEF);
    check("single_pending", {31'd0, any_pending}, 32'h1);
    out_ready = 8'h08;
    tick();
    out_ready = 8'h00;
    check("single_drained", {24'd0, out_valid}, 32'h00);
    check("single_hold", out_data[3*32 +: 32], 32'hDEADBEEF);

    // Backpressure isolation
    send(3'd5, 32'hA5A5A5A5, 1'b1);
    tick();
    send(3'd5, 32'h0BAD0BAD, 1'b0);
    send(3'd2, 32'h12345678, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_valid", {24'd0, out_valid}, 32'h24);
    check("bp_slice5", out_data[5*32 +: 32], 32'hA5A5A5A5);
    out_ready = 8'h24;
    tick();
    out_ready = 8'h00;
    check("bp_drained", {24'd0, out_valid}, 32'h00);

    // Back-to-back on channel 1 with consumer always ready
    out_ready = 8'h02;
    send(3'd1, 32'h1, 1'b1);
    tick();
    send(3'd1, 32'h2, 1'b1);
    check("b2b_v1", {31'd0, out_valid[1]}, 32'h1);
    tick();
    send(3'd1, 32'h3, 1'b1);
    check("b2b_v2", {31'd0, out_valid[1]}, 32'h1);
    tick();
    in_valid = 1'b0;
    check("b2b_v3", {31'd0, out_valid[1]}, 32'h1);
    check("b2b_last", out_data[1*32 +: 32], 32'h3);
    tick();
    out_ready = 8'h00;
    check("b2b_drained", {24'd0, out_valid}, 32'h00);

    // Reset mid-operation discards held words
    send(3'd0, 32'h11, 1'b1);
    tick();
    send(3'd7, 32'h77, 1'b1);
    tick();
    in_valid = 1'b0;
    check("mid_valid", {24'd0, out_valid}, 32'h81);
    in_sel = 3'd7;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {24'd0, out_valid}, 32'h00);
    check("mid_rst_pending", {31'd0, any_pending}, 32'h0);
    check("mid_rst_ready", {31'd0, in_ready}, 32'h1);
    sbq.delete();
    tick();
    rst_n = 1'b1;
    send(3'd7, 32'hCAFEF00D, 1'b1);
    tick();
    in_valid = 1'b0;
    check("post_rst_valid", {24'd0, out_valid}, 32'h80);
    out_ready = 8'h80;
    tick();
    out_ready = 8'h00;
    check("post_rst_drained", {24'd0, out_valid}, 32'h00);

    // Seventeen drains on channel 6, then clear during a drain
    cnt_sel   = 3'd6;
    out_ready = 8'h40;
    for (int n = 1; n <= 17; n++) begin
      send(3'd6, 32'(n), 1'b1);
      tick();
    end
    in_valid = 1'b0;
    tick();
`ifdef ROUTE_CNT_EN
    check("cnt_saturated", 32'(cnt_out), 32'hF);
`else
    check("cnt_tied_zero", 32'(cnt_out), 32'h0);
`endif
    send(3'd6, 32'h66, 1'b1);
    tick();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr   = 1'b0;
    out_ready = 8'h00;
    check("cnt_after_clr", 32'(cnt_out), 32'h0);
    check("final_valid", {24'd0, out_valid}, 32'h00);
    check("sb_empty", 32'(sbq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
